// File: rtl/ram_block_copier_pkg.sv
// ---------------------------------------------------------------------------
// ram_block_copier_pkg
//   Shared definitions for the RAM block copier and the sync_ram instances it
//   drives: FSM state encoding and the default RAM geometry.
// ---------------------------------------------------------------------------
package ram_block_copier_pkg;

    // Default RAM geometry; instances may override via parameters.
    localparam int RAM_ADDR_WIDTH = 16;
    localparam int RAM_DATA_WIDTH = 32;

    // Copier FSM states. The encoding is fixed so that it can be decoded
    // directly from the debug state output.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage : ram_block_copier_pkg

// File: rtl/ram_block_copier.sv
// ---------------------------------------------------------------------------
// ram_block_copier
//   Copies a block of words from src_addr to dst_addr inside one single-port
//   synchronous RAM. Each word costs one READ cycle (RAM drives Dout
//   combinationally, captured at the end of the cycle) and one WRITE cycle.
//   Copy order is strictly ascending, i.e. a forward word-by-word copy.
//
// Ports
//   clk         : single clock, all state changes on posedge
//   rst         : synchronous active-high reset, aborts any copy (no done)
//   start       : command strobe, only honoured in IDLE
//   src_addr    : first source address, latched on accepted start
//   dst_addr    : first destination address, latched on accepted start
//   length      : word count, latched on accepted start (0 = no-op)
//   busy        : high in every state except IDLE
//   done        : one-cycle pulse when the copy has completed
//   words_done  : words written in the current/last copy
//   ram_addr    : RAM address
//   ram_din     : RAM write data
//   ram_we      : RAM write enable
//   ram_rd      : RAM read enable (Dout is undriven when low)
//   ram_dout    : RAM read data, valid in the same cycle as ram_rd
//   dbg_state   : registered FSM state for observation
//
// Handshake: start is a level sampled at posedge while IDLE; the command is
// accepted on that edge and further starts are ignored until IDLE returns.
// ---------------------------------------------------------------------------
module ram_block_copier
    import ram_block_copier_pkg::*;
#(
    parameter int ADDR_WIDTH = RAM_ADDR_WIDTH,
    parameter int DATA_WIDTH = RAM_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] src_addr,
    input  logic [ADDR_WIDTH-1:0] dst_addr,
    input  logic [ADDR_WIDTH-1:0] length,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] words_done,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_din,
    output logic                  ram_we,
    output logic                  ram_rd,
    input  logic [DATA_WIDTH-1:0] ram_dout,
    output logic [1:0]            dbg_state
);

    state_t                r_state;
    state_t                w_state_next;
    logic [ADDR_WIDTH-1:0] r_src;
    logic [ADDR_WIDTH-1:0] r_dst;
    logic [ADDR_WIDTH-1:0] r_len;
    logic [ADDR_WIDTH-1:0] r_idx;
    logic [ADDR_WIDTH-1:0] r_words_done;
    logic [DATA_WIDTH-1:0] r_word;
    logic [ADDR_WIDTH-1:0] w_idx_inc;

    assign w_idx_inc  = r_idx + ADDR_WIDTH'(1);
    assign words_done = r_words_done;
    assign dbg_state  = r_state;

    // State register plus datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_src        <= '0;
            r_dst        <= '0;
            r_len        <= '0;
            r_idx        <= '0;
            r_words_done <= '0;
            r_word       <= '0;
        end else begin
            r_state <= w_state_next;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_src        <= src_addr;
                        r_dst        <= dst_addr;
                        r_len        <= length;
                        r_idx        <= '0;
                        r_words_done <= '0;
                    end
                end
                ST_READ: begin
                    // Only place the word register loads: Dout is undriven
                    // outside READ.
                    r_word <= ram_dout;
                end
                ST_WRITE: begin
                    r_idx        <= w_idx_inc;
                    r_words_done <= r_words_done + ADDR_WIDTH'(1);
                end
                default: ;
            endcase
        end
    end

    // Next-state and output decode, all from the registered state so the
    // RAM strobes are glitch-free with respect to start/length inputs.
    always_comb begin
        w_state_next = r_state;
        busy         = 1'b0;
        done         = 1'b0;
        ram_rd       = 1'b0;
        ram_we       = 1'b0;
        ram_addr     = '0;
        ram_din      = '0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_next = (length != '0) ? ST_READ : ST_DONE;
                end
            end
            ST_READ: begin
                busy         = 1'b1;
                ram_rd       = 1'b1;
                ram_addr     = r_src + r_idx;   // wraps modulo 2**ADDR_WIDTH
                w_state_next = ST_WRITE;
            end
            ST_WRITE: begin
                busy         = 1'b1;
                ram_we       = 1'b1;
                ram_addr     = r_dst + r_idx;   // wraps modulo 2**ADDR_WIDTH
                ram_din      = r_word;
                w_state_next = (w_idx_inc == r_len) ? ST_DONE : ST_READ;
            end
            ST_DONE: begin
                busy         = 1'b1;
                done         = 1'b1;
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

endmodule : ram_block_copier

// File: tb/tb_ram_block_copier.sv
// ---------------------------------------------------------------------------
// tb_ram_block_copier
//   Bench for ram_block_copier with an 8-bit-address behavioural RAM.
//   Expected reads, writes and done events are queued by a reference model
//   of a forward word copy; a negedge monitor pops and compares them.
// ---------------------------------------------------------------------------
module tb_ram_block_copier;
    import ram_block_copier_pkg::*;

    localparam int AW = 8;
    localparam int DW = 32;
    localparam int DEPTH = 1 << AW;
    // Stands in for the undriven Dout while ram_rd is low.
    localparam logic [DW-1:0] NOT_DRIVEN = 32'hBAAD_F00D;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUT + RAM ----------------
    logic          start = 1'b0;
    logic [AW-1:0] src_addr = '0, dst_addr = '0, length = '0;
    logic          busy, done, ram_we, ram_rd;
    logic [AW-1:0] words_done, ram_addr;
    logic [DW-1:0] ram_din, ram_dout;
    logic [1:0]    dbg_state;

    ram_block_copier #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst(rst), .start(start),
        .src_addr(src_addr), .dst_addr(dst_addr), .length(length),
        .busy(busy), .done(done), .words_done(words_done),
        .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we),
        .ram_rd(ram_rd), .ram_dout(ram_dout), .dbg_state(dbg_state)
    );

    logic [DW-1:0] mem [DEPTH];
    logic          tb_wr = 1'b0;
    logic [AW-1:0] tb_addr = '0;
    logic [DW-1:0] tb_data = '0;

    always @(posedge clk) begin
        if (ram_we)     mem[ram_addr] <= ram_din;
        else if (tb_wr) mem[tb_addr]  <= tb_data;
    end
    assign ram_dout = ram_rd ? mem[ram_addr] : NOT_DRIVEN;

    // ---------------- scoreboard ----------------
    int n_vec = 0;
    int n_err = 0;

    logic [DW-1:0]    model_mem [DEPTH];
    logic [AW+DW-1:0] exp_q [$];        // expected writes {addr, data}
    logic [AW-1:0]    exp_rd_q [$];     // expected read addresses
    int               exp_done_cyc_q [$];
    logic [AW-1:0]    exp_done_wd_q [$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- monitor ----------------
    logic prev_done = 1'b0;
    always @(negedge clk) begin
        logic [AW+DW-1:0] w;
        if (rst) begin
            prev_done = 1'b0;
        end else begin
            check("busy_vs_state", {63'd0, busy}, {63'd0, dbg_state != ST_IDLE});
            if (ram_we && ram_rd) check("we_rd_exclusive", 64'd1, 64'd0);
            if (done && prev_done) check("done_pulse_width", 64'd2, 64'd1);
            if (ram_rd) begin
                if (exp_rd_q.size() == 0) check("unexpected_read", {56'd0, ram_addr}, 64'hFFFF);
                else check("read_addr", {56'd0, ram_addr}, {56'd0, exp_rd_q.pop_front()});
            end
            if (ram_we) begin
                if (exp_q.size() == 0) check("unexpected_write", {24'd0, ram_addr, ram_din}, 64'hFFFF);
                else begin
                    w = exp_q.pop_front();
                    check("write_addr_data", {24'd0, ram_addr, ram_din}, {24'd0, w});
                end
            end
            if (done) begin
                if (exp_done_cyc_q.size() == 0) check("unexpected_done", 64'd1, 64'd0);
                else begin
                    check("done_cycle", 64'(cyc), 64'(exp_done_cyc_q.pop_front()));
                    check("done_words", {56'd0, words_done}, {56'd0, exp_done_wd_q.pop_front()});
                end
            end
            prev_done = done;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic poke(input logic [AW-1:0] a, input logic [DW-1:0] d);
        @(negedge clk);
        tb_wr = 1'b1; tb_addr = a; tb_data = d;
        model_mem[a] = d;
        @(negedge clk);
        tb_wr = 1'b0;
    endtask

    task automatic preload_random();
        for (int i = 0; i < DEPTH; i++) poke(AW'(i), $urandom);
    endtask

    // Reference: forward copy, one word at a time, addresses modulo 2**AW.
    task automatic expect_copy(input logic [AW-1:0] s, input logic [AW-1:0] d,
                               input int n_reads, input int n_writes);
        for (int i = 0; i < n_reads; i++) exp_rd_q.push_back(AW'(s + AW'(i)));
        for (int i = 0; i < n_writes; i++) begin
            logic [AW-1:0] sa, da;
            sa = AW'(s + AW'(i));
            da = AW'(d + AW'(i));
            exp_q.push_back({da, model_mem[sa]});
            model_mem[da] = model_mem[sa];
        end
    endtask

    task automatic start_cmd(input logic [AW-1:0] s, input logic [AW-1:0] d,
                             input logic [AW-1:0] n, output int acc);
        @(negedge clk);
        src_addr = s; dst_addr = d; length = n; start = 1'b1;
        @(posedge clk);
        #1;
        acc = cyc;
        start = 1'b0;
        src_addr = AW'($urandom); dst_addr = AW'($urandom); length = AW'($urandom);
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy && n < budget);
        if (busy) check({name, "_timeout"}, 64'd1, 64'd0);
        check({name, "_reads_left"}, 64'(exp_rd_q.size()), 64'd0);
        check({name, "_writes_left"}, 64'(exp_q.size()), 64'd0);
        check({name, "_done_left"}, 64'(exp_done_cyc_q.size()), 64'd0);
        exp_rd_q.delete(); exp_q.delete(); exp_done_cyc_q.delete(); exp_done_wd_q.delete();
    endtask

    task automatic compare_mem(input string name);
        for (int i = 0; i < DEPTH; i++) check(name, {32'd0, mem[i]}, {32'd0, model_mem[i]});
    endtask

    task automatic run_copy(input string name, input logic [AW-1:0] s,
                            input logic [AW-1:0] d, input logic [AW-1:0] n,
                            input bit disturb);
        int acc;
        expect_copy(s, d, int'(n), int'(n));
        start_cmd(s, d, n, acc);
        exp_done_cyc_q.push_back(acc + 2 * int'(n));
        exp_done_wd_q.push_back(n);
        if (disturb) begin
            repeat (3) @(negedge clk);
            src_addr = AW'($urandom); dst_addr = AW'($urandom); length = 8'd3;
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        wait_idle(name, 2 * int'(n) + 10);
        check({name, "_words_done"}, {56'd0, words_done}, {56'd0, n});
        compare_mem({name, "_mem"});
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int acc;
        for (int i = 0; i < DEPTH; i++) begin
            mem[i] = '0;
            model_mem[i] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_done", {63'd0, done}, 64'd0);
        check("rst_we", {63'd0, ram_we}, 64'd0);
        check("rst_rd", {63'd0, ram_rd}, 64'd0);
        check("rst_addr", {56'd0, ram_addr}, 64'd0);
        check("rst_din", {32'd0, ram_din}, 64'd0);
        check("rst_words_done", {56'd0, words_done}, 64'd0);
        check("rst_state", {62'd0, dbg_state}, {62'd0, ST_IDLE});
        @(negedge clk);
        rst = 1'b0;

        // Basic copy of four words, neighbour left untouched.
        preload_random();
        for (int i = 0; i < 4; i++) poke(AW'(8'h10 + i), 32'hA0 + DW'(i));
        run_copy("basic", 8'h10, 8'h40, 8'd4, 1'b0);

        // Zero length: done next cycle, no RAM traffic.
        run_copy("len0", 8'h33, 8'h55, 8'd0, 1'b0);

        // Source wraps past the top of the address space.
        run_copy("wrap", 8'hFE, 8'h20, 8'd3, 1'b0);

        // Overlapping forward copy smears the first word.
        for (int i = 0; i < 4; i++) poke(AW'(i), DW'(i + 1));
        run_copy("overlap", 8'h00, 8'h01, 8'd3, 1'b0);
        for (int i = 1; i < 4; i++) check("overlap_value", {32'd0, mem[i]}, 64'd1);

        // A second start while busy is ignored.
        run_copy("restart_ignored", 8'h80, 8'h90, 8'd8, 1'b1);

        // Reset after two written words of a five-word copy.
        expect_copy(8'h60, 8'hA0, 3, 2);
        start_cmd(8'h60, 8'hA0, 8'd5, acc);
        repeat (5) @(negedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
        check("abort_busy", {63'd0, busy}, 64'd0);
        check("abort_done", {63'd0, done}, 64'd0);
        check("abort_words_done", {56'd0, words_done}, 64'd0);
        check("abort_state", {62'd0, dbg_state}, {62'd0, ST_IDLE});
        @(negedge clk);
        #1 rst = 1'b0;
        wait_idle("abort", 4);
        compare_mem("abort_mem");
        run_copy("after_abort", 8'hC0, 8'hC8, 8'd5, 1'b0);

        // Randomised copies.
        for (int t = 0; t < 12; t++) begin
            if (t % 4 == 0) preload_random();
            run_copy("random", AW'($urandom), AW'($urandom),
                     AW'($urandom_range(0, 12)), 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Global watchdog so the run always ends on its own.
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1);
    end

endmodule : tb_ram_block_copier
